fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/register-file stage.
- Generates sequential PCs and fetches words from a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO and presents {pc, instruction} to decode with valid/ready.
- Accepts a branch/jump redirect that flushes the buffer and restarts fetch at a new PC.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  XLEN  fetch address; stable while imem_req is high.
- imem_ack  in  1  memory completion; imem_rdata is valid in this cycle.
- imem_rdata  in  XLEN  fetched instruction word.
- redirect  in  1  one-cycle pulse to flush and restart at redirect_pc.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored and forced to 0.
- if_valid  out  1  FIFO head holds a valid instruction.
- if_instr  out  XLEN  head instruction; 0 when if_valid=0.
- if_pc  out  XLEN  PC of the head instruction; 0 when if_valid=0.
- if_ready  in  1  decode accepts the head; a pop occurs when if_valid & if_ready.

Behaviour:
- Reset (synchronous, highest priority):
  - state=RUN, fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0.
- FSM states: RUN, DISCARD.
- RUN:
  - imem_req = (count < DEPTH), or a request is already in flight; imem_addr = fetch_pc.
  - Once raised, imem_req stays high with addr unchanged until imem_ack. It is never withdrawn except by reset or redirect handling.
  - On an ack cycle with no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^XLEN; wraps 0xFFFF_FFFC→0).
- Redirect in RUN:
  - Flush the FIFO (count=0, pointers=0) and set fetch_pc=redirect_pc & ~3.
  - If a request is outstanding and imem_ack=0 in that cycle: go to DISCARD.
  - If imem_ack=1 in the same cycle: drop the returned word and stay in RUN.
  - If no request is outstanding: stay in RUN.
- DISCARD:
  - Keep imem_req=1 with the old address until imem_ack; drop imem_rdata; then return to RUN. The new fetch starts the following cycle.
  - No push occurs; if_valid=0.
  - A further redirect in DISCARD only updates fetch_pc.
- FIFO:
  - if_valid = (count != 0); outputs come from the head entry (combinational).
  - Push and pop in the same cycle are legal: count is unchanged and the pointers both advance.
  - Push at full cannot occur, because a request is only issued when count < DEPTH and count cannot grow while it is in flight.
  - Pop at empty is ignored.
  - A pop in the redirect cycle is honoured as a handshake, but the flush overrides the result.
- Latency and throughput:
  - With an ack in the same cycle as req, the word appears on if_valid the next cycle.
  - With a continuously ready decode, sustained throughput is 1 instruction/cycle.
  - After a redirect with no outstanding request, the first req at the new PC is issued the next cycle.
- Reset mid-request:
  - imem_req drops immediately and no push occurs.
  - The instruction memory treats reset as an abort; a late ack arriving after reset is ignored until the first new req.

Test Plan:
1. Reset, then zero-wait memory returning word=addr|0x13, with if_ready=1 → if_pc sequence 0,4,8,12 on consecutive cycles; if_instr=0x13,0x17,0x1B,0x1F.
2. Hold if_ready=0, zero-wait memory → exactly DEPTH=4 pushes (pc 0..12), then imem_req=0 and count=4. Then raise if_ready for 1 cycle → one pop (pc 0) and one new req at pc 16.
3. Memory ack delayed 3 cycles → imem_req/imem_addr held stable all 3 cycles; a single push on the ack cycle only.
4. Redirect to 0x103 while a req is outstanding with ack arriving 2 cycles later → FIFO emptied next cycle; old word discarded; next req at 0x100; first if_pc=0x100.
5. Redirect and imem_ack in the same cycle with FIFO holding 2 entries → ack data dropped, if_valid=0 next cycle, fetch resumes at the redirect PC.
6. Assert reset mid-request with count=3 → next cycle imem_req=0, if_valid=0, imem_addr=RESET_PC; fetch restarts at RESET_PC after reset is released.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, req/ack memory
// port, prefetch FIFO toward decode and redirect flush handling.
module fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {RUN, DISCARD} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_entry_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] disc_addr_q, disc_addr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  if_entry_t       mem_q [DEPTH];
  if_entry_t       head;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = redirect_pc & ~XLEN'(3);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    imem_req = 1'b0;
    if (!reset) begin
      imem_req = (state_q == DISCARD) || (count_q != FULL);
    end
  end

  assign imem_addr = (state_q == DISCARD) ? disc_addr_q
                                          : fetch_pc_q;

  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? head.pc : '0;
  assign if_instr = if_valid ? head.instr : '0;

  assign pop  = if_valid & if_ready;
  assign push = imem_req & imem_ack
              & (state_q == RUN) & ~redirect;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    disc_addr_d = disc_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          fetch_pc_d = redir_pc;
          // an unacked request must still be drained at its old address
          if (imem_req && !imem_ack) begin
            state_d     = DISCARD;
            disc_addr_d = fetch_pc_q;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
        end
        if (imem_ack) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      disc_addr_q <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      disc_addr_q <= disc_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, slow memory,
// redirects, PC wrap and mid-request reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  logic        zw;
  logic        ack_man;
  logic [31:0] rdata_man;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_ack   = zw ? imem_req : ack_man;
  assign imem_rdata = zw ? (imem_addr | 32'h13) : rdata_man;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    zw = 1'b1; ack_man = 1'b0; rdata_man = '0;
    if_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    reset = 1'b1;
    step();
    step();
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_req got %b exp 0", imem_req);
    end
    tests++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b exp 0", if_valid);
    end
    tests++;
    if (imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_addr got %h exp 0", imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[i]
          || if_instr !== (exp_pc[i] | 32'h13)) begin
        fails++;
        $display("FAIL stream%0d got v=%b pc=%h ins=%h exp pc=%h ins=%h",
                 i, if_valid, if_pc, if_instr,
                 exp_pc[i], exp_pc[i] | 32'h13);
      end
    end
  endtask

  task automatic test_backpressure();
    zw = 1'b1; if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (imem_req !== 1'b0 || if_pc !== 32'h0) begin
      fails++;
      $display("FAIL bp_full got req=%b pc=%h exp req=0 pc=0",
               imem_req, if_pc);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_pc !== 32'h4) begin
      fails++;
      $display("FAIL bp_pop got req=%b addr=%h pc=%h exp 1 10 4",
               imem_req, imem_addr, if_pc);
    end
    step();
    tests++;
    if (imem_req !== 1'b0 || if_pc !== 32'h4) begin
      fails++;
      $display("FAIL bp_refill got req=%b pc=%h exp 0 4",
               imem_req, if_pc);
    end
  endtask

  task automatic test_slow_mem();
    zw = 1'b0; ack_man = 1'b0; if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
        fails++;
        $display("FAIL slow_wait%0d got req=%b addr=%h v=%b exp 1 0 0",
                 i, imem_req, imem_addr, if_valid);
      end
    end
    ack_man = 1'b1; rdata_man = 32'hDEAD_0013;
    step();
    ack_man = 1'b0;
    #1;
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hDEAD_0013
        || imem_addr !== 32'h4) begin
      fails++;
      $display("FAIL slow_push got v=%b pc=%h ins=%h addr=%h exp 1 0 dead0013 4",
               if_valid, if_pc, if_instr, imem_addr);
    end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    tests++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL slow_single got v=%b exp 0", if_valid);
    end
  endtask

  task automatic test_redirect_inflight();
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    #1;
    tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      fails++;
      $display("FAIL disc_hold got v=%b req=%b addr=%h exp 0 1 4",
               if_valid, imem_req, imem_addr);
    end
    step();
    ack_man = 1'b1; rdata_man = 32'h0000_0BAD;
    step();
    ack_man = 1'b0;
    #1;
    tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      fails++;
      $display("FAIL disc_done got v=%b req=%b addr=%h exp 0 1 100",
               if_valid, imem_req, imem_addr);
    end
    ack_man = 1'b1; rdata_man = 32'h1234_5013;
    step();
    ack_man = 1'b0;
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h1234_5013) begin
      fails++;
      $display("FAIL redir_first got v=%b pc=%h ins=%h exp 1 100 12345013",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_ack();
    zw = 1'b1; if_ready = 1'b0;
    do_reset();
    step();
    step();
    zw = 1'b0; ack_man = 1'b1; rdata_man = 32'h0000_FFFF;
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0; ack_man = 1'b0;
    #1;
    tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      fails++;
      $display("FAIL redir_ack got v=%b req=%b addr=%h exp 0 1 200",
               if_valid, imem_req, imem_addr);
    end
    zw = 1'b1;
    step();
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h213) begin
      fails++;
      $display("FAIL redir_ack_next got v=%b pc=%h ins=%h exp 1 200 213",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap();
    zw = 1'b1; if_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    step();
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL wrap_top got v=%b pc=%h ins=%h exp 1 fffffffc ffffffff",
               if_valid, if_pc, if_instr);
    end
    step();
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h13) begin
      fails++;
      $display("FAIL wrap_zero got v=%b pc=%h ins=%h exp 1 0 13",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_reset_midreq();
    zw = 1'b1; if_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    zw = 1'b0; ack_man = 1'b0;
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC || if_pc !== 32'h0) begin
      fails++;
      $display("FAIL mid_pre got req=%b addr=%h pc=%h exp 1 c 0",
               imem_req, imem_addr, if_pc);
    end
    reset = 1'b1;
    step();
    tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL mid_rst got req=%b v=%b addr=%h exp 0 0 0",
               imem_req, if_valid, imem_addr);
    end
    reset = 1'b0; zw = 1'b1;
    step();
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h13) begin
      fails++;
      $display("FAIL mid_restart got v=%b pc=%h ins=%h exp 1 0 13",
               if_valid, if_pc, if_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_slow_mem();
    test_redirect_inflight();
    test_redirect_ack();
    test_wrap();
    test_reset_midreq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
